// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Holds the default geometry, the requester identifiers and the read tag
// that travels alongside each RAM read until its data emerges.
package ram_arb_pkg;

    localparam int AW_DEF = 4;
    localparam int DW_DEF = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // One in-flight read: vld marks a real read, id names who issued it.
    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

endpackage

// File: rtl/ram_port_arbiter_rd_tag_pipe.sv
// Read tag delay line for the RAM arbiter.
// Delays each issued tag by exactly RD_LAT cycles, so the tag at the output
// lines up with the RAM data produced by the read that pushed it.
// The clear is asynchronous, so reads in flight are dropped by a reset.
module rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rstn,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t [RD_LAT-1:0] stage;

    // Shift tags one stage per cycle and discard them all on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two
// requesters. One access is granted per cycle. Grant and RAM drive are
// combinational, and reads are tagged so that their data goes back to
// the issuer RD_LAT cycles later. All outputs are forced to zero while
// rstn is low, including the combinational grant path.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rstn,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    // Requester that wins when both are valid in the same cycle.
    logic          ptr;
    logic          gnt0;
    logic          gnt1;
    tag_t          tag_in;
    tag_t          tag_out;
    logic          hit0;
    logic          hit1;
    logic [DW-1:0] hold0;
    logic [DW-1:0] hold1;

    // Pick a winner: a lone requester always wins, a tie goes to ptr.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rstn) begin
            if (req0_valid && req1_valid) begin
                gnt0 = (ptr == REQ0);
                gnt1 = (ptr == REQ1);
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Route the granted request onto the RAM port, idle port is all zero.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (gnt0) begin
            mem_we   = req0_we;
            mem_addr = req0_addr;
            mem_din  = req0_wdata;
        end else if (gnt1) begin
            mem_we   = req1_we;
            mem_addr = req1_addr;
            mem_din  = req1_wdata;
        end
    end

    // Hand priority to the other requester after every grant, hold when idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= REQ0;
        end else if (gnt0) begin
            ptr <= REQ1;
        end else if (gnt1) begin
            ptr <= REQ0;
        end
    end

    // Tag each granted read with its issuer; writes push an empty tag.
    always_comb begin
        tag_in.vld = (gnt0 && !req0_we) || (gnt1 && !req1_we);
        tag_in.id  = gnt1 ? REQ1 : REQ0;
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .rstn    (rstn),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign hit0 = tag_out.vld && (tag_out.id == REQ0);
    assign hit1 = tag_out.vld && (tag_out.id == REQ1);

    // Remember the last delivered word per requester so rdata holds between pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            if (hit0) begin
                hold0 <= mem_dout;
            end
            if (hit1) begin
                hold1 <= mem_dout;
            end
        end
    end

    assign rsp0_valid = hit0;
    assign rsp1_valid = hit1;
    assign rsp0_rdata = hit0 ? mem_dout : hold0;
    assign rsp1_rdata = hit1 ? mem_dout : hold1;

endmodule
